// File: rtl/uart_word_pkg.sv
// Shared types for the UART word loader: FSM state encoding and status codes.
package uart_word_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK    = 2'b00;
  localparam status_t ST_RXERR = 2'b01;
  localparam status_t ST_TMO   = 2'b10;
  localparam status_t ST_OVF   = 2'b11;

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle timer: a down-counter reloaded by clr, decremented while en,
// flagging expiry at terminal count (TIMEOUT-1 idle clocks after the reload).
module idle_timer #(
  parameter int TIMEOUT = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Reload on clear, otherwise count down to zero and hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/uart_word_loader.sv
// Assembles UART receive bytes into N-bit words and writes a frame of WORDS
// words into RAM starting at a base address sampled on the frame's first byte.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for the first byte of a frame
// S_COLLECT | shifting bytes in, writing each completed word
// S_DONE    | frame written, frame_valid held until frame_ack
module uart_word_loader
  import uart_word_pkg::*;
#(
  parameter int N         = 256,
  parameter int ABITS     = 8,
  parameter int WORDS     = 4,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 25000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  input  logic             rx_error,
  input  logic [ABITS-1:0] base_addr,
  output logic [ABITS-1:0] wr_addr,
  output logic [N-1:0]     wr_data,
  output logic             wr_en,
  output logic             frame_valid,
  output logic [ABITS-1:0] frame_base,
  input  logic             frame_ack,
  output logic             abort,
  output logic [1:0]       status,
  output logic             busy
);

  localparam int BYTES = N / 8;
  localparam int BCW   = $clog2(BYTES);
  localparam int WIW   = ABITS + 1;  // must hold WORDS itself, up to 2^ABITS
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [WIW-1:0] WORDS_W   = WIW'(WORDS);

  state_t           state, state_nx;
  logic [N-1:0]     sh, sh_nx, sh_in;
  logic [BCW-1:0]   byte_cnt, byte_cnt_nx;
  logic [WIW-1:0]   word_idx, word_idx_nx;
  logic [ABITS-1:0] wr_addr_nx, frame_base_nx;
  logic [N-1:0]     wr_data_nx;
  logic             wr_en_nx, abort_nx;
  status_t          status_nx;
  logic             full, tmr_clr, tmr_en, tmr_exp;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign sh_in = {sh[N-9:0], rx_byte};
    end else begin : g_lsb
      assign sh_in = {rx_byte, sh[N-1:8]};
    end
  endgenerate

  // Last write of the frame has been issued; move to DONE on the next edge.
  assign full = (word_idx == WORDS_W);

  assign tmr_en  = (state == S_COLLECT);
  assign tmr_clr = (state != S_COLLECT) || (rx_valid && !rx_error);

  idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  // Next-state and next-output decode; error beats byte, byte beats timeout.
  always_comb begin
    state_nx      = state;
    sh_nx         = sh;
    byte_cnt_nx   = byte_cnt;
    word_idx_nx   = word_idx;
    wr_en_nx      = 1'b0;
    wr_addr_nx    = wr_addr;
    wr_data_nx    = wr_data;
    frame_base_nx = frame_base;
    abort_nx      = 1'b0;
    status_nx     = status_t'(status);

    case (state)
      S_IDLE: begin
        if (rx_valid && !rx_error) begin
          state_nx      = S_COLLECT;
          frame_base_nx = base_addr;
          status_nx     = ST_OK;
          sh_nx         = sh_in;
          byte_cnt_nx   = BCW'(1);
          word_idx_nx   = '0;
        end
      end

      S_COLLECT: begin
        if (full) begin
          state_nx = S_DONE;
          if (rx_valid) begin
            status_nx = ST_OVF;
          end
        end else if (rx_error) begin
          state_nx    = S_IDLE;
          abort_nx    = 1'b1;
          status_nx   = ST_RXERR;
          byte_cnt_nx = '0;
          word_idx_nx = '0;
        end else if (rx_valid) begin
          sh_nx = sh_in;
          if (byte_cnt == LAST_BYTE) begin
            wr_data_nx  = sh_in;
            wr_addr_nx  = frame_base + word_idx[ABITS-1:0];
            wr_en_nx    = 1'b1;
            byte_cnt_nx = '0;
            word_idx_nx = word_idx + WIW'(1);
          end else begin
            byte_cnt_nx = byte_cnt + BCW'(1);
          end
        end else if (tmr_exp) begin
          state_nx    = S_IDLE;
          abort_nx    = 1'b1;
          status_nx   = ST_TMO;
          byte_cnt_nx = '0;
          word_idx_nx = '0;
        end
      end

      S_DONE: begin
        if (rx_valid) begin
          status_nx = ST_OVF;
        end
        if (frame_ack) begin
          state_nx    = S_IDLE;
          word_idx_nx = '0;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sh         <= '0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_base <= '0;
      abort      <= 1'b0;
      status     <= ST_OK;
    end else begin
      state      <= state_nx;
      sh         <= sh_nx;
      byte_cnt   <= byte_cnt_nx;
      word_idx   <= word_idx_nx;
      wr_en      <= wr_en_nx;
      wr_addr    <= wr_addr_nx;
      wr_data    <= wr_data_nx;
      frame_base <= frame_base_nx;
      abort      <= abort_nx;
      status     <= status_nx;
    end
  end

  assign frame_valid = (state == S_DONE);
  assign busy        = (state != S_IDLE);

endmodule
